// File: rtl/ili9163_pkg.sv
// Shared opcodes, decoder state encoding and window helpers for the ILI9163 SPI receiver.
package ili9163_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CASET_P = 3'd1,
    ST_RASET_P = 3'd2,
    ST_RAMWR   = 3'd3,
    ST_SKIP    = 3'd4
  } dec_state_e;

  // One axis of the address window: first and last index, both inclusive.
  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
  } axis_t;

  // A window is accepted only if both high bytes are zero, start <= end and end <= max.
  function automatic logic win_ok(input logic [7:0]  start_hi,
                                  input logic [7:0]  start_lo,
                                  input logic [7:0]  end_hi,
                                  input logic [7:0]  end_lo,
                                  input logic [15:0] max_idx);
    return (start_hi == 8'h00) && (end_hi == 8'h00) &&
           (start_lo <= end_lo) && ({8'h00, end_lo} <= max_idx);
  endfunction

endpackage

// File: rtl/ili9163_spi_shift.sv
// Synchronizes the SPI pins into clk, detects sck rising edges and assembles
// MSB-first bytes, emitting a one-cycle byte_strobe with the byte and its dc bit.
module ili9163_spi_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       byte_strobe
);

  // Bit order in the synchronizer vectors: {sck, cs, mosi, dc}.
  logic [3:0] sync_meta_q, sync_meta_d;
  logic [3:0] sync_q,      sync_d;
  logic       sck_prev_q,  sck_prev_d;
  logic       rise_q,      rise_d;
  logic       mosi_cap_q,  mosi_cap_d;
  logic       dc_cap_q,    dc_cap_d;
  logic [6:0] shift_q,     shift_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [7:0] rx_byte_q,   rx_byte_d;
  logic       rx_dc_q,     rx_dc_d;
  logic       strobe_q,    strobe_d;

  logic sck_s, cs_s, mosi_s, dc_s;
  assign {sck_s, cs_s, mosi_s, dc_s} = sync_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sync_meta_d = {spi_sck, spi_cs, spi_mosi, spi_dc};
    sync_d      = sync_meta_q;
    sck_prev_d  = sck_s;
    rise_d      = sck_s & ~sck_prev_q;
    // mosi/dc are frozen at the detected edge and consumed one cycle later with rise_q.
    mosi_cap_d  = rise_d ? mosi_s : mosi_cap_q;
    dc_cap_d    = rise_d ? dc_s   : dc_cap_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_byte_d   = rx_byte_q;
    rx_dc_d     = rx_dc_q;
    strobe_d    = 1'b0;

    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (rise_q) begin
      shift_d   = {shift_q[5:0], mosi_cap_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_byte_d = {shift_q, mosi_cap_q};
        rx_dc_d   = dc_cap_q;
        strobe_d  = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
      sck_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      mosi_cap_q  <= 1'b0;
      dc_cap_q    <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rx_byte_q   <= '0;
      rx_dc_q     <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      sck_prev_q  <= sck_prev_d;
      rise_q      <= rise_d;
      mosi_cap_q  <= mosi_cap_d;
      dc_cap_q    <= dc_cap_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_byte_q   <= rx_byte_d;
      rx_dc_q     <= rx_dc_d;
      strobe_q    <= strobe_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_dc       = rx_dc_q;
  assign byte_strobe = strobe_q;

endmodule

// File: rtl/ili9163_spi_rx.sv
// ILI9163 panel-side SPI receiver: decodes CASET/RASET/RAMWR and streams RGB565
// pixels with their window coordinates.
module ili9163_spi_rx
  import ili9163_pkg::*;
#(
  parameter int unsigned MAX_X = 127,
  parameter int unsigned MAX_Y = 159
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  input  logic        spi_dc,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        px_valid,
  output logic [7:0]  px_x,
  output logic [7:0]  px_y,
  output logic [15:0] px_data,
  output logic        win_err
);

  localparam logic [15:0] MAX_X_W = 16'(MAX_X);
  localparam logic [15:0] MAX_Y_W = 16'(MAX_Y);
  localparam logic [7:0]  MAX_X_B = 8'(MAX_X);
  localparam logic [7:0]  MAX_Y_B = 8'(MAX_Y);

  logic [7:0] rx_byte;
  logic       rx_dc;
  logic       byte_strobe;

  ili9163_spi_shift u_shift (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .rx_byte    (rx_byte),
    .rx_dc      (rx_dc),
    .byte_strobe(byte_strobe)
  );

  dec_state_e  state_q,     state_d;
  logic [1:0]  param_idx_q, param_idx_d;
  logic [7:0]  start_hi_q,  start_hi_d;
  logic [7:0]  start_lo_q,  start_lo_d;
  logic [7:0]  end_hi_q,    end_hi_d;
  axis_t       x_win_q,     x_win_d;
  axis_t       y_win_q,     y_win_d;
  logic [7:0]  x_q,         x_d;
  logic [7:0]  y_q,         y_d;
  logic        phase_q,     phase_d;
  logic [7:0]  pix_hi_q,    pix_hi_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q,  cmd_byte_d;
  logic        px_valid_q,  px_valid_d;
  logic [7:0]  px_x_q,      px_x_d;
  logic [7:0]  px_y_q,      px_y_d;
  logic [15:0] px_data_q,   px_data_d;
  logic        win_err_q,   win_err_d;

  logic        is_caset;
  logic        param_ok;

  assign is_caset = (state_q == ST_CASET_P);
  assign param_ok = win_ok(start_hi_q, start_lo_q, end_hi_q, rx_byte,
                           is_caset ? MAX_X_W : MAX_Y_W);

  always_comb begin
    state_d     = state_q;
    param_idx_d = param_idx_q;
    start_hi_d  = start_hi_q;
    start_lo_d  = start_lo_q;
    end_hi_d    = end_hi_q;
    x_win_d     = x_win_q;
    y_win_d     = y_win_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = phase_q;
    pix_hi_d    = pix_hi_q;
    cmd_byte_d  = cmd_byte_q;
    px_x_d      = px_x_q;
    px_y_d      = px_y_q;
    px_data_d   = px_data_q;
    cmd_valid_d = 1'b0;
    px_valid_d  = 1'b0;
    win_err_d   = 1'b0;

    if (byte_strobe && !rx_dc) begin
      // A command always wins: it restarts whatever parameter sequence was in flight.
      cmd_valid_d = 1'b1;
      cmd_byte_d  = rx_byte;
      param_idx_d = 2'd0;
      case (rx_byte)
        CMD_CASET: state_d = ST_CASET_P;
        CMD_RASET: state_d = ST_RASET_P;
        CMD_RAMWR: begin
          state_d = ST_RAMWR;
          x_d     = x_win_q.lo;
          y_d     = y_win_q.lo;
          phase_d = 1'b0;
        end
        default:   state_d = ST_SKIP;
      endcase
    end else if (byte_strobe) begin
      case (state_q)
        ST_CASET_P, ST_RASET_P: begin
          param_idx_d = param_idx_q + 2'd1;
          case (param_idx_q)
            2'd0: start_hi_d = rx_byte;
            2'd1: start_lo_d = rx_byte;
            2'd2: end_hi_d   = rx_byte;
            2'd3: begin
              state_d = ST_IDLE;
              if (!param_ok) begin
                win_err_d = 1'b1;
              end else if (is_caset) begin
                x_win_d = '{lo: start_lo_q, hi: rx_byte};
              end else begin
                y_win_d = '{lo: start_lo_q, hi: rx_byte};
              end
            end
          endcase
        end
        ST_RAMWR: begin
          if (!phase_q) begin
            pix_hi_d = rx_byte;
            phase_d  = 1'b1;
          end else begin
            phase_d    = 1'b0;
            px_valid_d = 1'b1;
            px_x_d     = x_q;
            px_y_d     = y_q;
            px_data_d  = {pix_hi_q, rx_byte};
            // Raster advance inside the window, wrapping to the top-left corner.
            if (x_q < x_win_q.hi) begin
              x_d = x_q + 8'd1;
            end else begin
              x_d = x_win_q.lo;
              y_d = (y_q < y_win_q.hi) ? y_q + 8'd1 : y_win_q.lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      param_idx_q <= 2'd0;
      start_hi_q  <= 8'h00;
      start_lo_q  <= 8'h00;
      end_hi_q    <= 8'h00;
      x_win_q     <= '{lo: 8'h00, hi: MAX_X_B};
      y_win_q     <= '{lo: 8'h00, hi: MAX_Y_B};
      x_q         <= 8'h00;
      y_q         <= 8'h00;
      phase_q     <= 1'b0;
      pix_hi_q    <= 8'h00;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
      px_valid_q  <= 1'b0;
      px_x_q      <= 8'h00;
      px_y_q      <= 8'h00;
      px_data_q   <= 16'h0000;
      win_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      param_idx_q <= param_idx_d;
      start_hi_q  <= start_hi_d;
      start_lo_q  <= start_lo_d;
      end_hi_q    <= end_hi_d;
      x_win_q     <= x_win_d;
      y_win_q     <= y_win_d;
      x_q         <= x_d;
      y_q         <= y_d;
      phase_q     <= phase_d;
      pix_hi_q    <= pix_hi_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      px_valid_q  <= px_valid_d;
      px_x_q      <= px_x_d;
      px_y_q      <= px_y_d;
      px_data_q   <= px_data_d;
      win_err_q   <= win_err_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign px_valid  = px_valid_q;
  assign px_x      = px_x_q;
  assign px_y      = px_y_q;
  assign px_data   = px_data_q;
  assign win_err   = win_err_q;

endmodule

// File: tb/tb_ili9163_spi_rx.sv
// Scoreboard bench for ili9163_spi_rx: stimulus pushes expected events, a
// negedge monitor pops and compares every cmd/pixel/window-error pulse.
module tb_ili9163_spi_rx;

  localparam time HALF = 40ns;

  localparam logic [1:0] K_CMD = 2'd1;
  localparam logic [1:0] K_PX  = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  cmd;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_dc = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        px_valid;
  logic [7:0]  px_x;
  logic [7:0]  px_y;
  logic [15:0] px_data;
  logic        win_err;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  lat;

  ili9163_spi_rx #(.MAX_X(127), .MAX_Y(159)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_sck  (spi_sck),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .spi_dc   (spi_dc),
    .cmd_valid(cmd_valid),
    .cmd_byte (cmd_byte),
    .px_valid (px_valid),
    .px_x     (px_x),
    .px_y     (px_y),
    .px_data  (px_data),
    .win_err  (win_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic score(input string name, input ev_t act);
    ev_t req;
    req = '0;
    if (exp_q.size() > 0) req = exp_q.pop_front();
    check(name, 64'(act), 64'(req));
  endtask

  always @(negedge clk) begin : monitor
    int n;
    n = 0;
    if (rst) begin
      if (cmd_valid) begin n++; score("cmd_event", {K_CMD, cmd_byte, 32'h0}); end
      if (px_valid)  begin n++; score("px_event",  {K_PX, 8'h00, px_x, px_y, px_data}); end
      if (win_err)   begin n++; score("err_event", {K_ERR, 40'h0}); end
      if (n > 1) check("pulse_overlap", 64'(n), 64'd1);
    end
  end

  task automatic exp_cmd(input logic [7:0] b);
    exp_q.push_back({K_CMD, b, 32'h0});
  endtask

  task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
    spi_dc = dc;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      #(HALF) spi_sck = 1'b1;
      #(HALF) spi_sck = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    exp_cmd(b);
    spi_bits(1'b0, b, 8);
  endtask

  task automatic send_data(input logic [7:0] b);
    spi_bits(1'b1, b, 8);
  endtask

  task automatic send_px(input logic [15:0] d, input logic [7:0] x, input logic [7:0] y);
    exp_q.push_back({K_PX, 8'h00, x, y, d});
    send_data(d[15:8]);
    send_data(d[7:0]);
  endtask

  task automatic send_win(input logic [7:0] cmd, input logic [7:0] sh, input logic [7:0] sl,
                          input logic [7:0] eh, input logic [7:0] el, input logic bad);
    send_cmd(cmd);
    if (bad) exp_q.push_back({K_ERR, 40'h0});
    send_data(sh);
    send_data(sl);
    send_data(eh);
    send_data(el);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    #(HALF) spi_cs = 1'b1;
    #(HALF * 3);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    check({tag, "_cmd_byte"},  64'(cmd_byte),  64'd0);
    check({tag, "_px_valid"},  64'(px_valid),  64'd0);
    check({tag, "_px_x"},      64'(px_x),      64'd0);
    check({tag, "_px_y"},      64'(px_y),      64'd0);
    check({tag, "_px_data"},   64'(px_data),   64'd0);
    check({tag, "_win_err"},   64'(win_err),   64'd0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // CASET 2..5 with a latency measurement on the command's final bit.
    cs_low();
    exp_cmd(8'h2A);
    spi_bits(1'b0, 8'h2A, 7);
    spi_mosi = 1'b0;
    #(HALF) spi_sck = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (cmd_valid) break;
    end
    check("cmd_latency", 64'(lat), 64'd4);
    @(negedge clk);
    spi_sck = 1'b0;
    send_data(8'h00); send_data(8'h02); send_data(8'h00); send_data(8'h05);

    // Window x 2..5 over full height: row wraps after x=5.
    send_cmd(8'h2C);
    send_px(16'hAAAA, 8'd2, 8'd0);
    send_px(16'h5555, 8'd3, 8'd0);
    send_px(16'h0001, 8'd4, 8'd0);
    send_px(16'h8000, 8'd5, 8'd0);
    send_px(16'hFFFF, 8'd2, 8'd1);

    // 2x2 window, then wrap back to its corner; an extra CASET data byte is ignored.
    send_win(8'h2A, 8'h00, 8'h02, 8'h00, 8'h03, 1'b0);
    send_data(8'h77);
    send_win(8'h2B, 8'h00, 8'h01, 8'h00, 8'h02, 1'b0);
    send_cmd(8'h2C);
    send_px(16'hF800, 8'd2, 8'd1);
    send_px(16'hF800, 8'd3, 8'd1);
    send_px(16'hF800, 8'd2, 8'd2);
    send_px(16'hF800, 8'd3, 8'd2);
    send_px(16'h07E0, 8'd2, 8'd1);

    // Rejected windows leave the old one in place.
    send_win(8'h2A, 8'h00, 8'h09, 8'h00, 8'h04, 1'b1);
    send_cmd(8'h2C);
    send_px(16'h1234, 8'd2, 8'd1);
    send_win(8'h2A, 8'h01, 8'h00, 8'h00, 8'h05, 1'b1);
    send_win(8'h2B, 8'h00, 8'h00, 8'h00, 8'hA0, 1'b1);
    send_win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h9F, 1'b0);

    // Aborted CASET, then a pixel split across a cs-high gap.
    send_cmd(8'h2A);
    send_data(8'h00); send_data(8'h07);
    send_cmd(8'h2C);
    exp_q.push_back({K_PX, 8'h00, 8'd2, 8'd0, 16'hBEEF});
    send_data(8'hBE);
    cs_high();
    cs_low();
    send_data(8'hEF);
    send_px(16'hCAFE, 8'd3, 8'd0);

    // Unknown opcode: its data bytes are skipped.
    send_cmd(8'h11);
    send_data(8'h12); send_data(8'h34);

    // Partial byte discarded by cs high.
    spi_bits(1'b0, 8'hFF, 5);
    cs_high();
    cs_low();
    send_cmd(8'h2C);
    send_px(16'h0102, 8'd2, 8'd0);

    // Reset in the middle of a pixel.
    send_data(8'hAB);
    spi_bits(1'b1, 8'hCD, 4);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    cs_high();
    cs_low();
    send_cmd(8'h2C);
    send_px(16'h4321, 8'd0, 8'd0);
    cs_high();

    repeat (20) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ili9163_spi_rx.md
ILI9163_SPI_RX -- requirements
Module: ili9163_spi_rx

Interface
REQ-001 Parameter MAX_X, default 127, last valid column index.
REQ-002 Parameter MAX_Y, default 159, last valid row index.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 spi_sck  input  1  panel serial clock, asynchronous to clk.
REQ-006 spi_cs  input  1  chip select, active-low.
REQ-007 spi_mosi  input  1  serial data, MSB first, sampled on sck rising edge.
REQ-008 spi_dc  input  1  0 = command byte, 1 = data byte.
REQ-009 cmd_valid  output  1  one-cycle pulse, command byte received.
REQ-010 cmd_byte  output  8  last command opcode, held until next command.
REQ-011 px_valid  output  1  one-cycle pulse, pixel written.
REQ-012 px_x  output  8  pixel column, valid with px_valid.
REQ-013 px_y  output  8  pixel row, valid with px_valid.
REQ-014 px_data  output  16  RGB565 pixel, valid with px_valid.
REQ-015 win_err  output  1  one-cycle pulse, illegal window parameters rejected.

Function
REQ-016 spi_sck, spi_cs, spi_mosi, spi_dc pass a 2-FF synchronizer; a registered rising-edge detect on synced sck gates bit capture.
REQ-017 Correct operation requires clk frequency at least 4x sck frequency; slower clk is unsupported.
REQ-018 Bits shift in only while synced cs=0; 3-bit counter; eighth bit completes a byte, dc sampled with that bit.
REQ-019 Synced cs=1 clears bit counter and discards any partial byte; decoder state and window are kept.
REQ-020 cmd_valid/px_valid assert exactly 4 clk cycles after the first clk edge at which spi_sck is sampled high for the byte's final bit.
REQ-021 Decoder FSM states: IDLE, CASET_P (4 params), RASET_P (4 params), RAMWR, SKIP.
REQ-022 Any command byte (dc=0), in any state, pulses cmd_valid, updates cmd_byte, and aborts any parameter sequence.
REQ-023 Command 0x2A -> CASET_P; 0x2B -> RASET_P; 0x2C -> RAMWR; any other opcode -> SKIP (data bytes ignored).
REQ-024 CASET_P/RASET_P collect start_hi, start_lo, end_hi, end_lo; after the 4th byte the FSM returns to IDLE; extra data bytes are ignored.
REQ-025 Window committed after the 4th byte only; start = low 8 bits of {hi,lo}; a start>end, end>MAX, or nonzero hi byte rejects the update, keeps the old window, and pulses win_err.
REQ-026 Entering RAMWR loads cursor x=xs, y=ys and clears the byte-phase flag.
REQ-027 In RAMWR, data bytes pair: first = px_data[15:8], second = px_data[7:0]; px_valid pulses on the second byte.
REQ-028 After each pixel: x<xe -> x+1; x=xe -> x=xs and y+1; at x=xe,y=ye -> wrap to x=xs,y=ys.
REQ-029 cs high mid-pixel keeps the byte phase; RAMWR resumes on next cs low.
REQ-030 px_valid and cmd_valid never assert in the same cycle.

Reset
REQ-031 rst=0 asynchronously clears synchronizers, shift register, bit counter, all pulses, cmd_byte=0x00, px_x=px_y=0, px_data=0, FSM=IDLE.
REQ-032 Reset window: xs=0, xe=MAX_X, ys=0, ye=MAX_Y.
REQ-033 Reset mid-byte or mid-pixel discards partial data; no pulse follows the reset release.

Structure
REQ-034 Package ili9163_pkg holds opcodes CMD_CASET=0x2A, CMD_RASET=0x2B, CMD_RAMWR=0x2C and the decoder state enum.
REQ-035 Sub-module ili9163_spi_shift holds synchronizer, edge detect, and bit/byte assembly; it outputs byte, dc, byte_strobe.

Verification
REQ-036 Send cmd 0x2A, data 00 02 00 05 -> cmd_valid once, cmd_byte=0x2A, no win_err, window x 2..5.
REQ-037 CASET 2..3, RASET 00 01 00 02, RAMWR, 4 pixels 0xF800 -> px_valid at (2,1),(3,1),(2,2),(3,2), px_data=0xF800 each.
REQ-038 Continue to a fifth pixel 0x07E0 -> wrap, px at (2,1), px_data=0x07E0.
REQ-039 CASET 00 09 00 04 -> win_err pulse, window unchanged; next RAMWR pixel at the old xs,ys.
REQ-040 Raise cs after 5 bits, lower cs, send full byte 0x2C -> only 0x2C decoded; assert rst during a pixel byte -> all outputs return to reset values and no px_valid.
